// File: rtl/pe_bus_arbiter.sv
// Shared tri-state bus arbiter: fixed-priority host, round-robin PEs, dead turnaround between owners.
// Optional hold watchdog built only when PE_BUS_ARB_TIMEOUT_EN is defined.
module pe_bus_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int IDW       = 3,
  parameter int MAX_HOLD  = 32,
  parameter int TA_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  input  logic               host_req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               host_gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               bus_oe_o,
  output logic               busy_o,
  output logic               timeout_o
);
  localparam int TAW = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOST, S_OWN, S_TURN} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [TAW-1:0]     ta_q, ta_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               host_gnt_q, host_gnt_d;
  logic [IDW-1:0]     ptr_inc, cand, arb_idx;
  logic               arb_hit, arbitrate, hold_expired;

  assign ptr_inc = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
      if (!arb_hit && req_i[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

`ifdef PE_BUS_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q;

  assign hold_expired = (state_q == S_OWN) && req_i[id_q] && !last_i[id_q] &&
                        (hold_q == HW'(MAX_HOLD - 1));
  assign hold_d       = (state_q == S_OWN && state_d == S_OWN) ? hold_q + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= hold_expired;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign hold_expired = 1'b0;
  // Without the watchdog MAX_HOLD has no effect; this expression is constant 0.
  assign timeout_o    = (MAX_HOLD < 0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      ta_q       <= '0;
      gnt_q      <= '0;
      host_gnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      ta_q       <= ta_d;
      gnt_q      <= gnt_d;
      host_gnt_q <= host_gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    ta_d      = ta_q;
    arbitrate = 1'b0;
    case (state_q)
      S_IDLE: arbitrate = 1'b1;
      S_HOST: begin
        if (!host_req_i) begin
          state_d = S_TURN;
          ta_d    = '0;
        end
      end
      S_OWN: begin
        if (!req_i[id_q] || last_i[id_q] || hold_expired) begin
          state_d = S_TURN;
          ta_d    = '0;
          ptr_d   = ptr_inc;
        end
      end
      S_TURN: begin
        if (ta_q == TAW'(TA_CYCLES - 1)) arbitrate = 1'b1;
        else                             ta_d      = ta_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (arbitrate) begin
      if (host_req_i) begin
        state_d = S_HOST;
      end else if (arb_hit) begin
        state_d = S_OWN;
        id_d    = arb_idx;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Grants are decoded from the next state so they appear registered.
  always_comb begin
    gnt_d      = '0;
    host_gnt_d = (state_d == S_HOST);
    if (state_d == S_OWN) gnt_d[id_d] = 1'b1;
  end

  assign gnt_o      = gnt_q;
  assign host_gnt_o = host_gnt_q;
  assign gnt_id_o   = id_q;
  assign bus_oe_o   = |gnt_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Self-checking bench for pe_bus_arbiter: directed sequences, a vector table, and random
// traffic against an ownership-level reference model.
module tb_pe_bus_arbiter;
  localparam int N  = 8;
  localparam int TA = 1;
  localparam int MH = 4;
`ifdef PE_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] last = '0;
  logic         host = 1'b0;
  logic [N-1:0] gnt;
  logic         hg;
  logic [2:0]   gid;
  logic         oe, busy, to;
  logic [14:0]  dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_bus_arbiter #(.NUM_REQ(N), .IDW(3), .MAX_HOLD(MH), .TA_CYCLES(TA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .last_i(last), .host_req_i(host),
    .gnt_o(gnt), .host_gnt_o(hg), .gnt_id_o(gid), .bus_oe_o(oe), .busy_o(busy),
    .timeout_o(to)
  );

  assign dut_vec = {gnt, hg, gid, oe, busy, to};

  // Reference model: owner -1 = nobody, -2 = host, else PE index.
  int m_owner, m_dead, m_ptr, m_held, m_id;
  bit m_to;

  function automatic void model_reset();
    m_owner = -1; m_dead = 0; m_ptr = 0; m_held = 0; m_id = 0; m_to = 1'b0;
  endfunction

  function automatic void model_step(logic [N-1:0] r, logic [N-1:0] l, logic h);
    m_to = 1'b0;
    if (m_owner == -2) begin
      if (!h) begin m_owner = -1; m_dead = TA; end
    end else if (m_owner >= 0) begin
      m_held++;
      if (!r[m_owner] || l[m_owner] || (TO_EN && m_held >= MH)) begin
        m_to    = TO_EN && r[m_owner] && !l[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_dead  = TA;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      if (h) m_owner = -2;
      else
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && r[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_id    = m_owner;
            m_held  = 0;
          end
    end
  endfunction

  function automatic logic [14:0] model_out();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    return {g, m_owner == -2, 3'(m_id), |g, (m_owner != -1) || (m_dead > 0), m_to};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step(req, last, host);
    else       model_reset();
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req, last;
    logic         host;
    logic [N-1:0] gnt;
    logic         hg, busy;
    logic [2:0]   id;
  } vec_t;
  vec_t tbl[20];

  initial begin
    // Starts from IDLE with ptr=1.
    tbl[0]  = '{8'h20, 8'h00, 1'b0, 8'h20, 1'b0, 1'b1, 3'd5};
    tbl[1]  = '{8'h20, 8'h20, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5};
    tbl[2]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5};
    tbl[3]  = '{8'h05, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0};
    tbl[4]  = '{8'h05, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{8'h04, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2};
    tbl[6]  = '{8'h04, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2};
    tbl[8]  = '{8'h10, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 3'd2};
    tbl[9]  = '{8'h10, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 3'd2};
    tbl[10] = '{8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2};
    tbl[11] = '{8'h10, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1, 3'd4};
    tbl[12] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4};
    tbl[13] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4};
    tbl[14] = '{8'h08, 8'h00, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3};
    tbl[15] = '{8'h08, 8'h00, 1'b1, 8'h08, 1'b0, 1'b1, 3'd3};
    tbl[16] = '{8'h08, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 3'd3};
    tbl[17] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 3'd3};
    tbl[18] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3};
    tbl[19] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3};

    model_reset();
    req = 8'hFF;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_outs", 32'({gnt, hg, busy, oe, to}), 32'(0));
    rst_n = 1'b1;
    step();
    chk("first_gnt", 32'(gnt), 32'h01);

    // Round-robin: each owner sends last on its second beat.
    for (int k = 0; k < N; k++) begin
      step();
      chk("rr_beat2", 32'(gnt), 32'(1 << k));
      last = N'(1 << k);
      step();
      chk("rr_dead", 32'({gnt, busy}), 32'({8'h00, 1'b1}));
      last = '0;
      step();
      chk("rr_next", 32'({gnt, gid}), 32'({N'(1 << ((k + 1) % N)), 3'((k + 1) % N)}));
    end
    req = '0;
    step();
    chk("abandon_turn", 32'({gnt, busy}), 32'({8'h00, 1'b1}));
    step();
    chk("idle_busy", 32'(busy), 32'(0));

    for (int k = 0; k < 20; k++) begin
      req = tbl[k].req; last = tbl[k].last; host = tbl[k].host;
      step();
      chk($sformatf("vec%0d", k), 32'({gnt, hg, busy, gid}),
          32'({tbl[k].gnt, tbl[k].hg, tbl[k].busy, tbl[k].id}));
    end

    // Move ptr to 0, then PE3 abandons, which must move ptr to 4.
    req = 8'h80; step(); chk("ab_p7", 32'(gnt), 32'h80);
    last = 8'h80; step();
    req = '0; last = '0; step();
    req = 8'h08; step(); chk("ab_p3", 32'(gnt), 32'h08);
    req = '0; step(); chk("ab_turn", 32'({gnt, busy}), 32'({8'h00, 1'b1}));
    req = 8'h18; step(); chk("ab_ptr4", 32'(gnt), 32'h10);

    // Asynchronous reset mid-grant.
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 32'({gnt, hg, busy}), 32'(0));
    model_reset();
    req = '0;
    @(negedge clk) rst_n = 1'b1;

`ifdef PE_BUS_ARB_TIMEOUT_EN
    req = 8'h0C;
    step(); chk("to_grant", 32'(gnt), 32'h04);
    for (int k = 0; k < MH - 1; k++) begin
      step(); chk("to_hold", 32'({gnt, to}), 32'({8'h04, 1'b0}));
    end
    step(); chk("to_revoke", 32'({gnt, to}), 32'({8'h00, 1'b1}));
    step(); chk("to_next", 32'({gnt, to}), 32'({8'h08, 1'b0}));
    req = '0; step(); step();
`endif

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (req[p]) begin
          if ($urandom_range(7) == 0) req[p] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          req[p] = 1'b1;
        end
      end
      last = N'($urandom) & N'($urandom);
      if (host) begin
        if ($urandom_range(3) == 0) host = 1'b0;
      end else if ($urandom_range(19) == 0) begin
        host = 1'b1;
      end
      step();
      chk("rand", 32'(dut_vec), 32'(model_out()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
